// File: rtl/nibble_serial_add_ctrl_if.sv
// Operand/result handshake bundle for nibble_serial_add_ctrl.
//   master : producer of operands and consumer of results (drives in_valid, A, B, out_ready)
//   slave  : the adder controller (drives in_ready, out_valid, Sum, Cout)
// Optional macro ADDER_SUB_EN adds the 'sub' request bit sampled with A/B.
interface nibble_serial_add_ctrl_if #(
  parameter int unsigned N = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [N:1]   A;
  logic [N:1]   B;
  logic         out_valid;
  logic         out_ready;
  logic [N:1]   Sum;
  logic         Cout;
`ifdef ADDER_SUB_EN
  logic         sub;
`endif

  modport master (
`ifdef ADDER_SUB_EN
    output sub,
`endif
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, Sum, Cout
  );

  modport slave (
`ifdef ADDER_SUB_EN
    input  sub,
`endif
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, Sum, Cout
  );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// Multi-cycle N-bit adder: one 4-bit ripple slice reused over N/4 steps, LSB nibble
// first, with the inter-nibble carry held in a register.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset, priority over everything
//   bus  : nibble_serial_add_ctrl_if.slave (in_valid/in_ready/A/B, out_valid/out_ready/Sum/Cout)
// Optional macro ADDER_SUB_EN: accepts bus.sub; sub=1 computes A-B as A+~B+1
// (Cout=1 means no borrow). Undefined: add only.
module nibble_serial_add_ctrl #(
  parameter int unsigned N = 16
) (
  input logic                   clk,
  input logic                   rst,
  nibble_serial_add_ctrl_if.slave bus
);

  localparam int unsigned STEPS = N / 4;
  localparam int unsigned SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned LAST  = STEPS - 1;

  generate
    if ((N % 4) != 0 || N < 4) begin : g_bad_n
      $error("nibble_serial_add_ctrl: N must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   step_q, step_d;
  logic            carry_q, carry_d;
  logic [N:1]      opa_q, opa_d;
  logic [N:1]      opb_q, opb_d;
  logic [N:1]      sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic            sub_c;
  logic [3:0]      slice_a_c, slice_b_c;
  logic [4:0]      nib_c;

`ifdef ADDER_SUB_EN
  assign sub_c = bus.sub;
`else
  assign sub_c = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= '0;
      carry_q     <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      carry_q     <= carry_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Slice operand select and the shared 4-bit add
  always_comb begin
    slice_a_c = 4'h0;
    slice_b_c = 4'h0;
    for (int unsigned s = 0; s < STEPS; s++) begin
      if (step_q == SW'(s)) begin
        slice_a_c = opa_q[4*s+1 +: 4];
        slice_b_c = opb_q[4*s+1 +: 4];
      end
    end
    nib_c = {1'b0, slice_a_c} + {1'b0, slice_b_c} + {4'h0, carry_q};
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // Subtract stores ~B and seeds the carry with 1 (two's complement)
          opa_d   = bus.A;
          opb_d   = bus.B ^ {N{sub_c}};
          carry_d = sub_c;
          step_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int unsigned s = 0; s < STEPS; s++) begin
          if (step_q == SW'(s)) begin
            sum_d[4*s+1 +: 4] = nib_c[3:0];
          end
        end
        carry_d = nib_c[4];
        step_d  = step_q + SW'(1);
        if (step_q == SW'(LAST)) begin
          cout_d  = nib_c[4];
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake flags registered from the upcoming state
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.Sum       = sum_q;
  assign bus.Cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed + random bench for nibble_serial_add_ctrl (N=16 and N=8 instances).
module tb_nibble_serial_add_ctrl;

  localparam int unsigned N  = 16;
  localparam int unsigned N8 = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nibble_serial_add_ctrl_if #(.N(N))  bus ();
  nibble_serial_add_ctrl_if #(.N(N8)) bus8 ();

  nibble_serial_add_ctrl #(.N(N))  dut  (.clk(clk), .rst(rst), .bus(bus.slave));
  nibble_serial_add_ctrl #(.N(N8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

  int checks = 0;
  int errors = 0;
  logic [N:0]  sb_q [$];
  logic [N8:0] sb8_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands at a negedge, push the model result, let the accepting edge pass
  task automatic send(input logic [N:1] a, input logic [N:1] b, input logic s);
    logic [N:1] bb;
    bus.A        = a;
    bus.B        = b;
    bus.in_valid = 1'b1;
`ifdef ADDER_SUB_EN
    bus.sub      = s;
`endif
    check("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
    bb = s ? ~b : b;
    sb_q.push_back({1'b0, a} + {1'b0, bb} + {{N{1'b0}}, s});
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.A        = N'($urandom);
    bus.B        = N'($urandom);
    check("in_ready_after_accept", 64'(bus.in_ready), 64'd0);
  endtask

  task automatic wait_result();
    int cnt;
    logic [N:0] exp;
    cnt = 0;
    while (bus.out_valid !== 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("latency", 64'(cnt), 64'(N/4));
    if (sb_q.size() == 0) begin
      check("scoreboard_nonempty", 64'd0, 64'd1);
    end else begin
      exp = sb_q.pop_front();
      check("sum",  64'(bus.Sum),  64'(exp[N-1:0]));
      check("cout", 64'(bus.Cout), 64'(exp[N]));
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("out_valid_after_release", 64'(bus.out_valid), 64'd0);
    check("in_ready_after_release",  64'(bus.in_ready),  64'd1);
  endtask

  initial begin
    logic [N:1] held_sum;
    logic       held_cout;
    int         cnt;
    logic       seen;

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.A = '0; bus.B = '0;
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b0; bus8.A = '0; bus8.B = '0;
`ifdef ADDER_SUB_EN
    bus.sub = 1'b0; bus8.sub = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_in_ready",  64'(bus.in_ready),  64'd1);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_sum",       64'(bus.Sum),       64'd0);
    check("reset_cout",      64'(bus.Cout),      64'd0);

    // T1
    send(16'h1234, 16'h4321, 1'b0);
    wait_result();
    check("t1_sum_const", 64'(bus.Sum), 64'h5555);
    release_result();

    // T2: carry ripples across every step
    send(16'hFFFF, 16'h0001, 1'b0);
    wait_result();
    check("t2_sum_const",  64'(bus.Sum),  64'h0000);
    check("t2_cout_const", 64'(bus.Cout), 64'd1);
    release_result();

    // T3: back-pressure in DONE with new operands waiting
    send(16'hA5A5, 16'h5A5B, 1'b0);
    wait_result();
    held_sum  = bus.Sum;
    held_cout = bus.Cout;
    bus.A = 16'h0F0F; bus.B = 16'h1111; bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3_sum_held",   64'(bus.Sum),       64'(held_sum));
      check("t3_cout_held",  64'(bus.Cout),      64'(held_cout));
      check("t3_in_ready",   64'(bus.in_ready),  64'd0);
      check("t3_out_valid",  64'(bus.out_valid), 64'd1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("t3_release_out_valid", 64'(bus.out_valid), 64'd0);
    check("t3_not_accepted_yet",  64'(bus.in_ready),  64'd1);
    send(16'h0F0F, 16'h1111, 1'b0);
    wait_result();
    check("t3_new_sum_const", 64'(bus.Sum), 64'h2020);
    release_result();

    // T4: reset during step 2 aborts the operation
    send(16'h1357, 16'h2468, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    check("t4_in_ready",  64'(bus.in_ready),  64'd1);
    check("t4_out_valid", 64'(bus.out_valid), 64'd0);
    check("t4_sum",       64'(bus.Sum),       64'd0);
    check("t4_cout",      64'(bus.Cout),      64'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen = 1'b1;
    end
    check("t4_no_out_valid", 64'(seen), 64'd0);
    send(16'h00FF, 16'h0001, 1'b0);
    wait_result();
    check("t4_sum_const", 64'(bus.Sum), 64'h0100);
    release_result();

    // Random adds, back-to-back
    for (int i = 0; i < 12; i++) begin
      send(N'($urandom), N'($urandom), 1'b0);
      wait_result();
      release_result();
    end

`ifdef ADDER_SUB_EN
    // T6: subtract
    send(16'h0005, 16'h0007, 1'b1);
    wait_result();
    check("t6a_sum_const",  64'(bus.Sum),  64'hFFFE);
    check("t6a_cout_const", 64'(bus.Cout), 64'd0);
    release_result();
    send(16'h0007, 16'h0005, 1'b1);
    wait_result();
    check("t6b_sum_const",  64'(bus.Sum),  64'h0002);
    check("t6b_cout_const", 64'(bus.Cout), 64'd1);
    release_result();
    for (int i = 0; i < 6; i++) begin
      send(N'($urandom), N'($urandom), 1'($urandom));
      wait_result();
      release_result();
    end
`endif

    // T5: N=8 instance
    bus8.A = 8'hF0; bus8.B = 8'h10; bus8.in_valid = 1'b1;
    check("t5_in_ready", 64'(bus8.in_ready), 64'd1);
    sb8_q.push_back({1'b0, 8'hF0} + {1'b0, 8'h10});
    @(negedge clk);
    bus8.in_valid = 1'b0;
    cnt = 0;
    while (bus8.out_valid !== 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("t5_latency", 64'(cnt), 64'd2);
    if (sb8_q.size() != 0) begin
      logic [N8:0] e8;
      e8 = sb8_q.pop_front();
      check("t5_sum",  64'(bus8.Sum),  64'(e8[N8-1:0]));
      check("t5_cout", 64'(bus8.Cout), 64'(e8[N8]));
    end
    check("t5_sum_const", 64'(bus8.Sum), 64'h00);
    bus8.out_ready = 1'b1;
    @(negedge clk);
    bus8.out_ready = 1'b0;
    check("t5_release", 64'(bus8.out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
